// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit and its users.
// Holds the "operand unused" Tuse encoding, the default Tnew per
// instruction class, and the forward-select value that means "read the GRF".
// No ports.
package hazard_unit_pkg;

  // Tuse value meaning the instruction does not read that operand.
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Cycles after E entry until the result exists, per instruction class.
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_JAL  = 2'd0;

  // Forward select value for "no forwarding, use the register file".
  localparam int FWD_GRF = 0;

  typedef enum logic [1:0] {
    IC_ALU  = 2'd0,
    IC_LOAD = 2'd1,
    IC_JAL  = 2'd2,
    IC_NONE = 2'd3
  } instr_class_e;

  // Default Tnew for a decoded instruction class; classes that write
  // nothing report 0, the caller gates them with d_wr_en anyway.
  function automatic logic [1:0] class_tnew(input instr_class_e c);
    case (c)
      IC_ALU:  class_tnew = TNEW_ALU;
      IC_LOAD: class_tnew = TNEW_LOAD;
      IC_JAL:  class_tnew = TNEW_JAL;
      default: class_tnew = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage <-> hazard unit bundle.
// master : the decode stage; drives the per-instruction control fields and
//          receives stall / forward selects / md_busy.
// slave  : the hazard unit.
// Signals: d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr,
//          d_tnew, d_md_start, d_md_use (D -> unit);
//          stall, fwd_rs_sel, fwd_rt_sel, md_busy (unit -> D).
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int SW     = 2
);

  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  logic              d_wr_en;
  logic [REG_AW-1:0] d_wr_addr;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_use;

  logic              stall;
  logic [SW-1:0]     fwd_rs_sel;
  logic [SW-1:0]     fwd_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
           d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_use,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
           d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_use,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

endinterface

// File: rtl/hazard_unit_match.sv
// hazard_match: compares one D-stage source register against the DEPTH
// in-flight writer entries (index 0 = stage 1 = E, the youngest).
// Ports:
//   src_i   source register address
//   tuse_i  cycles until the source is needed (all-ones = unused)
//   vld_i / addr_i / tnew_i  per-stage writer entries
//   stall_o winning writer will not have its result in time
//   sel_o   stage number to forward from, 0 = GRF
module hazard_match
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int SW     = 2
) (
  input  logic [REG_AW-1:0]            src_i,
  input  logic [TW-1:0]                tuse_i,
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0][REG_AW-1:0] addr_i,
  input  logic [DEPTH-1:0][TW-1:0]     tnew_i,
  output logic                         stall_o,
  output logic [SW-1:0]                sel_o
);

  logic active;
  logic hit;

  always_comb begin
    stall_o = 1'b0;
    sel_o   = SW'(FWD_GRF);
    hit     = 1'b0;
    // $0 is hard-wired and unused operands never create a dependence.
    active  = (src_i != '0) && (tuse_i != {TW{1'b1}});
    // Scan from the youngest stage; the first match shadows older writers.
    for (int k = 0; k < DEPTH; k++) begin
      if (active && !hit && vld_i[k] && (addr_i[k] == src_i)) begin
        hit     = 1'b1;
        stall_o = (tnew_i[k] > tuse_i);
        // A result that is still being produced is not forwarded from here;
        // the later stage muxes pick it up once it exists.
        sel_o   = (tnew_i[k] == '0) ? SW'(k + 1) : SW'(FWD_GRF);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: Tnew/Tuse scoreboard for the pipelined core.
// Tracks register writers through DEPTH stages after decode, produces the
// D-stage stall, rs/rt forward selects, and the mult/div busy interlock.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; clears all tracking and the md counter
//   bus    hazard_unit_if.slave (D-stage control fields in, stall/fwd/md_busy out)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int MD_LAT = 5,
  parameter int SW     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave bus
);

  localparam int CW = $clog2(MD_LAT + 1);

  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [DEPTH-1:0][REG_AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][TW-1:0]     tnew_q, tnew_d;
  logic [CW-1:0]                md_cnt_q, md_cnt_d;

  logic          rs_term, rt_term, md_term;
  logic [SW-1:0] rs_sel, rt_sel;
  logic          stall;
  logic          md_busy;

  hazard_match #(
    .DEPTH (DEPTH),
    .REG_AW(REG_AW),
    .TW    (TW),
    .SW    (SW)
  ) u_match_rs (
    .src_i  (bus.d_rs),
    .tuse_i (bus.d_tuse_rs),
    .vld_i  (vld_q),
    .addr_i (addr_q),
    .tnew_i (tnew_q),
    .stall_o(rs_term),
    .sel_o  (rs_sel)
  );

  hazard_match #(
    .DEPTH (DEPTH),
    .REG_AW(REG_AW),
    .TW    (TW),
    .SW    (SW)
  ) u_match_rt (
    .src_i  (bus.d_rt),
    .tuse_i (bus.d_tuse_rt),
    .vld_i  (vld_q),
    .addr_i (addr_q),
    .tnew_i (tnew_q),
    .stall_o(rt_term),
    .sel_o  (rt_sel)
  );

  // D stage: combinational decision from D inputs and the registered entries.
  assign md_busy = (md_cnt_q != '0);
  assign md_term = bus.d_valid & bus.d_md_use & md_busy;
  assign stall   = bus.d_valid & (rs_term | rt_term | md_term);

  assign bus.stall      = stall;
  assign bus.md_busy    = md_busy;
  assign bus.fwd_rs_sel = stall ? SW'(FWD_GRF) : rs_sel;
  assign bus.fwd_rt_sel = stall ? SW'(FWD_GRF) : rt_sel;

  always_comb begin
    vld_d  = '0;
    addr_d = '0;
    tnew_d = '0;
    // A stalled D stage pushes a bubble into stage 1.
    vld_d[0]  = bus.d_valid & bus.d_wr_en & (bus.d_wr_addr != '0) & ~stall;
    addr_d[0] = bus.d_wr_addr;
    tnew_d[0] = bus.d_tnew;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      addr_d[k] = addr_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    // A start held off by a stall must not restart the busy window.
    if (bus.d_valid & bus.d_md_start & ~stall) begin
      md_cnt_d = CW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  // Stage 1..DEPTH boundary: control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      md_cnt_q <= '0;
    end else begin
      vld_q    <= vld_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Stage 1..DEPTH boundary: payload, only meaningful where vld_q is set.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    tnew_q <= tnew_d;
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  localparam int DEPTH  = 3;
  localparam int REG_AW = 5;
  localparam int TW     = 2;
  localparam int MD_LAT = 5;
  localparam int SW     = $clog2(DEPTH + 1);
  localparam int NONE   = 3;
  localparam int HN     = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(REG_AW), .TW(TW), .SW(SW)) bus ();

  hazard_unit #(
    .DEPTH (DEPTH),
    .REG_AW(REG_AW),
    .TW    (TW),
    .MD_LAT(MD_LAT),
    .SW    (SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a history of issued writers indexed by issue cycle.
  // A writer issued at cycle c sits in stage (now - c) and has produced
  // max(0, tnew - (age-1)) remaining cycles of latency.
  int cyc     = 0;
  int floor_c = 0;
  int md_s    = -100;
  bit hv [HN];
  int ha [HN];
  int ht [HN];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void src_eval(input int s, input int tu,
                                   output bit term, output int sel);
    term = 1'b0;
    sel  = 0;
    if (s == 0 || tu == NONE) return;
    for (int age = 1; age <= DEPTH; age++) begin
      int pc;
      pc = cyc - age;
      if (pc >= floor_c && hv[pc] && ha[pc] == s) begin
        int rem;
        rem  = ht[pc] - (age - 1);
        if (rem < 0) rem = 0;
        term = (rem > tu);
        sel  = (rem == 0) ? age : 0;
        return;
      end
    end
  endfunction

  // One D-stage cycle: drive after the falling edge, check before the
  // rising edge, then advance the model.
  task automatic cyc_in(input string tag, input bit rst, input bit dv,
                        input int rs, input int rt, input int trs, input int trt,
                        input bit wr, input int wa, input int tn,
                        input bit ms, input bit mu);
    bit t_rs, t_rt, busy, st;
    int s_rs, s_rt;
    @(negedge clk);
    reset          = rst;
    bus.d_valid    = dv;
    bus.d_rs       = REG_AW'(rs);
    bus.d_rt       = REG_AW'(rt);
    bus.d_tuse_rs  = TW'(trs);
    bus.d_tuse_rt  = TW'(trt);
    bus.d_wr_en    = wr;
    bus.d_wr_addr  = REG_AW'(wa);
    bus.d_tnew     = TW'(tn);
    bus.d_md_start = ms;
    bus.d_md_use   = mu;
    #1;
    src_eval(rs, trs, t_rs, s_rs);
    src_eval(rt, trt, t_rt, s_rt);
    busy = (md_s >= floor_c) && (cyc - md_s >= 1) && (cyc - md_s <= MD_LAT);
    st   = dv && (t_rs || t_rt || (mu && busy));
    if (!rst) begin
      chk({tag, ".stall"},   int'(bus.stall),      int'(st));
      chk({tag, ".rs_sel"},  int'(bus.fwd_rs_sel), st ? 0 : s_rs);
      chk({tag, ".rt_sel"},  int'(bus.fwd_rt_sel), st ? 0 : s_rt);
      chk({tag, ".md_busy"}, int'(bus.md_busy),    int'(busy));
    end
    hv[cyc] = dv && wr && (wa != 0) && !st;
    ha[cyc] = wa;
    ht[cyc] = tn;
    if (dv && ms && !st) md_s = cyc;
    if (rst) floor_c = cyc + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc_in("idle", 1'b0, 1'b0, 0, 0, NONE, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    cyc_in("rst", 1'b1, 1'b0, 0, 0, NONE, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc_in("rst", 1'b1, 1'b0, 0, 0, NONE, NONE, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset state
    cyc_in("post_rst", 1'b0, 1'b1, 3, 4, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("rst_stall",   int'(bus.stall), 0);
    chk("rst_rs_sel",  int'(bus.fwd_rs_sel), 0);
    chk("rst_rt_sel",  int'(bus.fwd_rt_sel), 0);
    chk("rst_md_busy", int'(bus.md_busy), 0);
    idle(3);

    // ALU add $3 then a Tuse=0 reader: one stall, then forward from stage 2
    cyc_in("alu_wr", 1'b0, 1'b1, 1, 2, 1, 1, 1'b1, 3, 1, 1'b0, 1'b0);
    cyc_in("alu_rd", 1'b0, 1'b1, 3, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("alu_stall1", int'(bus.stall), 1);
    cyc_in("alu_rd", 1'b0, 1'b1, 3, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("alu_stall2", int'(bus.stall), 0);
    chk("alu_fwd",    int'(bus.fwd_rs_sel), 2);
    idle(3);

    // lw $5 then beq $5 Tuse=0: two stall cycles, then the entry is in stage 3
    cyc_in("lw_wr", 1'b0, 1'b1, 1, 0, 1, NONE, 1'b1, 5, 2, 1'b0, 1'b0);
    cyc_in("beq", 1'b0, 1'b1, 5, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("lw_stall1", int'(bus.stall), 1);
    cyc_in("beq", 1'b0, 1'b1, 5, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("lw_stall2", int'(bus.stall), 1);
    cyc_in("beq", 1'b0, 1'b1, 5, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("lw_stall3", int'(bus.stall), 0);
    chk("lw_fwd",    int'(bus.fwd_rs_sel), 3);
    idle(3);

    // Two writers to $7: the youngest (stage 1) wins
    cyc_in("w7a", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 7, 0, 1'b0, 1'b0);
    cyc_in("w7b", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 7, 0, 1'b0, 1'b0);
    cyc_in("r7", 1'b0, 1'b1, 0, 7, NONE, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("young_stall", int'(bus.stall), 0);
    chk("young_fwd",   int'(bus.fwd_rt_sel), 1);
    idle(3);

    // $0 is never a dependence; unused operand never stalls
    cyc_in("w0", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 0, 2, 1'b0, 1'b0);
    cyc_in("r0", 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("r0_stall", int'(bus.stall), 0);
    chk("r0_sel",   int'(bus.fwd_rs_sel), 0);
    cyc_in("lw9", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 9, 2, 1'b0, 1'b0);
    cyc_in("unused9", 1'b0, 1'b1, 9, 9, NONE, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("unused_stall", int'(bus.stall), 0);
    idle(3);

    // mult then mfhi: busy for exactly MD_LAT cycles, a stalled mult does not reload
    cyc_in("mult", 1'b0, 1'b1, 1, 2, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < MD_LAT; i++) begin
      cyc_in("mfhi", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 8, 1, (i == 1), 1'b1);
      chk("md_stall", int'(bus.stall), 1);
      chk("md_busy",  int'(bus.md_busy), 1);
    end
    cyc_in("mfhi", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 8, 1, 1'b0, 1'b1);
    chk("md_done_stall", int'(bus.stall), 0);
    chk("md_done_busy",  int'(bus.md_busy), 0);
    idle(3);

    // Reset in the middle of a lw stall with mult/div busy
    cyc_in("mult2", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b0, 0, 0, 1'b1, 1'b1);
    cyc_in("lw5", 1'b0, 1'b1, 0, 0, NONE, NONE, 1'b1, 5, 2, 1'b0, 1'b0);
    cyc_in("beq", 1'b0, 1'b1, 5, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("mid_pre_stall", int'(bus.stall), 1);
    cyc_in("beq_rst", 1'b1, 1'b1, 5, 0, 0, NONE, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc_in("beq", 1'b0, 1'b1, 5, 5, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("mid_rst_stall",   int'(bus.stall), 0);
    chk("mid_rst_rs_sel",  int'(bus.fwd_rs_sel), 0);
    chk("mid_rst_rt_sel",  int'(bus.fwd_rt_sel), 0);
    chk("mid_rst_md_busy", int'(bus.md_busy), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc_in("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
